cpu_branch_resolver: RTL and testbench

Resolves control-transfer instructions at the execute stage against the prediction that fetch made from the branch target buffer. It detects mispredictions and issues a registered redirect to fetch, squashing the one-cycle wrong-path shadow. It also produces the write-side traffic for the branch target buffer's update port through a small update queue. It sits between the execute stage and the fetch-side branch target buffer, and is the producer of every branch target buffer update.

---
 rtl/cpu_branch_pkg.sv | 17 +
 rtl/cpu_branch_update_fifo.sv | 46 ++++
 rtl/cpu_branch_resolver.sv | 106 ++++++++++
 tb/tb_cpu_branch_resolver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_branch_pkg.sv
// Shared branch-resolution helpers, reused by the execute-side resolver and fetch-side checks.
package cpu_branch_pkg;

   localparam int INSTR_BYTES = 4;

   // The target comparison is passed in as a bit so these helpers stay independent of XLEN.
   function automatic logic is_mispredict(input logic taken, input logic pred_taken,
                                          input logic target_match);
      return (pred_taken != taken) || (taken && !target_match);
   endfunction

   function automatic logic needs_update(input logic taken, input logic pred_taken,
                                         input logic target_match);
      return taken && (!pred_taken || !target_match);
   endfunction

endpackage

// File: rtl/cpu_branch_update_fifo.sv
// Small FIFO for branch target buffer updates; the pointers carry an extra wrap bit for full/empty.
module cpu_branch_update_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is left unreset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= data;
   end

endmodule

// File: rtl/cpu_branch_resolver.sv
// Execute-stage branch resolver: registered redirect on mispredict, plus BTB update queue.
// Optional performance counters are enabled with the CPU_BRANCH_STATS_EN macro.
module cpu_branch_resolver
   import cpu_branch_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int UPDATE_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            update,
   output logic [XLEN-1:0] update_addr,
   output logic [XLEN-1:0] update_target_addr,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts,
   output logic [31:0]     stat_drops
);

   logic            accept;
   logic            target_match;
   logic            mispredict;
   logic            push;
   logic            push_ok;
   logic [XLEN-1:0] correct_pc;
   logic            q_full;
   logic            q_empty;
   logic            q_pop;
   logic [2*XLEN-1:0] q_head;

   // The instruction behind a redirect is wrong-path and must be ignored.
   assign accept       = ex_valid && !redirect;
   assign target_match = (ex_pred_target == ex_target);
   assign mispredict   = accept && is_mispredict(ex_taken, ex_pred_taken, target_match);
   assign push         = accept && needs_update(ex_taken, ex_pred_taken, target_match);
   assign correct_pc   = ex_taken ? ex_target : ex_pc + XLEN'(INSTR_BYTES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         redirect <= mispredict;
         if (mispredict) redirect_pc <= correct_pc;
      end
   end

   // The BTB always accepts, so the head is consumed on every non-empty cycle.
   assign q_pop   = !q_empty;
   assign push_ok = push && (!q_full || q_pop);

   cpu_branch_update_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (UPDATE_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok),
      .data  ({ex_pc, ex_target}),
      .pop   (q_pop),
      .full  (q_full),
      .empty (q_empty),
      .head  (q_head)
   );

   assign update             = !q_empty;
   assign update_addr        = q_empty ? '0 : q_head[2*XLEN-1:XLEN];
   assign update_target_addr = q_empty ? '0 : q_head[XLEN-1:0];

`ifdef CPU_BRANCH_STATS_EN
   logic        drop;
   logic [31:0] branches_q;
   logic [31:0] mispredicts_q;
   logic [31:0] drops_q;

   assign drop = push && !push_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branches_q    <= '0;
         mispredicts_q <= '0;
         drops_q       <= '0;
      end else begin
         if (accept)     branches_q    <= branches_q + 32'd1;
         if (mispredict) mispredicts_q <= mispredicts_q + 32'd1;
         if (drop)       drops_q       <= drops_q + 32'd1;
      end
   end

   assign stat_branches    = branches_q;
   assign stat_mispredicts = mispredicts_q;
   assign stat_drops       = drops_q;
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
   assign stat_drops       = '0;
`endif

endmodule

// File: tb/tb_cpu_branch_resolver.sv
// Directed self-checking bench for cpu_branch_resolver; stat expectations follow CPU_BRANCH_STATS_EN.
module tb_cpu_branch_resolver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        update;
   logic [31:0] update_addr;
   logic [31:0] update_target_addr;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
   logic [31:0] stat_drops;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef CPU_BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   cpu_branch_resolver #(.XLEN(32), .UPDATE_DEPTH(4)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .ex_valid           (ex_valid),
      .ex_pc              (ex_pc),
      .ex_taken           (ex_taken),
      .ex_target          (ex_target),
      .ex_pred_taken      (ex_pred_taken),
      .ex_pred_target     (ex_pred_target),
      .redirect           (redirect),
      .redirect_pc        (redirect_pc),
      .update             (update),
      .update_addr        (update_addr),
      .update_target_addr (update_target_addr),
      .stat_branches      (stat_branches),
      .stat_mispredicts   (stat_mispredicts),
      .stat_drops         (stat_drops)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
      ex_valid       = v;
      ex_pc          = pc;
      ex_taken       = tk;
      ex_target      = tgt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
      check({tag, "_update"},   {31'd0, update},   32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) cycle();

      check("rst_redirect",    {31'd0, redirect}, 32'd0);
      check("rst_redirect_pc", redirect_pc,       32'h0);
      check("rst_update",      {31'd0, update},   32'd0);
      check("rst_update_addr", update_addr,       32'h0);
      check("rst_update_tgt",  update_target_addr, 32'h0);
      check("rst_stat_br",     stat_branches,     32'd0);
      rst_n = 1'b1;
      cycle();

      // Correctly predicted taken branch: nothing happens.
      drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      cycle();
      idle();
      check_quiet("ok_c1");
      cycle();
      check_quiet("ok_c2");

      // Predicted not-taken, actually taken.
      drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      cycle();
      idle();
      check("pnt_redirect",    {31'd0, redirect}, 32'd1);
      check("pnt_redirect_pc", redirect_pc,       32'h200);
      check("pnt_update",      {31'd0, update},   32'd1);
      check("pnt_update_addr", update_addr,       32'h100);
      check("pnt_update_tgt",  update_target_addr, 32'h200);
      cycle();
      check_quiet("pnt_after");
      check("pnt_pc_hold", redirect_pc, 32'h200);

      // Predicted taken, actually not taken; the shadow instruction must be ignored.
      drive(1'b1, 32'h300, 1'b0, 32'h999, 1'b1, 32'h380);
      cycle();
      drive(1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 32'h0);
      check("pt_redirect",    {31'd0, redirect}, 32'd1);
      check("pt_redirect_pc", redirect_pc,       32'h304);
      check("pt_update",      {31'd0, update},   32'd0);
      cycle();
      idle();
      check_quiet("shadow_c1");
      check("shadow_pc_hold", redirect_pc, 32'h304);
      cycle();
      check_quiet("shadow_c2");

      // Right direction, wrong target.
      drive(1'b1, 32'h400, 1'b1, 32'h600, 1'b1, 32'h500);
      cycle();
      idle();
      check("wt_redirect_pc", redirect_pc,        32'h600);
      check("wt_update",      {31'd0, update},    32'd1);
      check("wt_update_addr", update_addr,        32'h400);
      check("wt_update_tgt",  update_target_addr, 32'h600);
      cycle();
      check_quiet("wt_after");

      // Three wrong-target branches, each accepted right after its squash shadow.
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 32'h10 * i, 1'b1, 32'h1000 + 32'h100 * i, 1'b1, 32'h2000);
         cycle();
         idle();
         check("seq_redirect",    {31'd0, redirect},  32'd1);
         check("seq_redirect_pc", redirect_pc,        32'h1000 + 32'h100 * i);
         check("seq_update",      {31'd0, update},    32'd1);
         check("seq_update_addr", update_addr,        32'h10 * i);
         check("seq_update_tgt",  update_target_addr, 32'h1000 + 32'h100 * i);
         cycle();
         check_quiet("seq_gap");
      end
      // Accepted: 1 + 1 + 1 + 1 + 3; mispredicts: 0 + 1 + 1 + 1 + 3.
      check("stat_branches",    stat_branches,    STATS ? 32'd7 : 32'd0);
      check("stat_mispredicts", stat_mispredicts, STATS ? 32'd6 : 32'd0);
      check("stat_drops",       stat_drops,       32'd0);

      // Fall-through wraps past the top of the address space.
      drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
      cycle();
      idle();
      check("wrap_redirect",    {31'd0, redirect}, 32'd1);
      check("wrap_redirect_pc", redirect_pc,       32'h0);
      check("wrap_update",      {31'd0, update},   32'd0);
      cycle();

      // Reset while an update is pending.
      drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
      cycle();
      idle();
      check("mid_update_before", {31'd0, update}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_update",      {31'd0, update},   32'd0);
      check("mid_rst_redirect",    {31'd0, redirect}, 32'd0);
      check("mid_rst_redirect_pc", redirect_pc,       32'h0);
      check("mid_rst_update_addr", update_addr,       32'h0);
      check("mid_rst_stat_br",     stat_branches,     32'd0);
      repeat (2) cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_quiet("post_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
